plot_arbiter: RTL
=================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter X_W, default 8, x-coordinate width.
REQ-002 Parameter Y_W, default 7, y-coordinate width.
REQ-003 Parameter C_W, default 3, colour width.
REQ-004 Parameter MAX_BURST, default 256, pixel-cycle limit per grant (watchdog).
REQ-005 Requester count is fixed at 3: index 0 self sprite, 1 enemy field, 2 HUD/score.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req  input  3  per-requester bus request, level, held for the whole burst.
REQ-009 pix_valid  input  3  per-requester pixel strobe.
REQ-010 pix_last  input  3  per-requester final-pixel marker, qualified by pix_valid.
REQ-011 x_in  input  3*X_W  packed x coordinates, requester i at bits [i*X_W +: X_W].
REQ-012 y_in  input  3*Y_W  packed y coordinates, same packing.
REQ-013 colour_in  input  3*C_W  packed colours, same packing.
REQ-014 clr_err  input  1  synchronous clear of timeout_err.
REQ-015 grant  output  3  one-hot (or zero) grant, registered.
REQ-016 busy  output  1  high while in state BURST.
REQ-017 plot  output  1  VGA write enable, registered.
REQ-018 x_out, y_out, colour_out  output  X_W, Y_W, C_W  registered VGA pixel.
REQ-019 timeout_err  output  1  sticky watchdog flag.

Function
REQ-020 FSM has two states: IDLE and BURST.
REQ-021 IDLE with req != 0: select winner by round-robin from (last_winner+1) mod 3 upward; grant[winner] = 1 and state = BURST on the next edge.
REQ-022 IDLE with req == 0: grant = 0; FSM stays in IDLE.
REQ-023 BURST: a pixel is accepted only when pix_valid[g] & grant[g]; on the following edge plot = 1 and the outputs carry that requester's x/y/colour.
REQ-024 Fixed pixel latency is 1 cycle from accepted pix_valid to plot; plot = 0 in every other cycle.
REQ-025 pix_valid from non-granted requesters is ignored: no plot, no state change.
REQ-026 Accepted pix_last: that pixel is still plotted; grant clears and state = IDLE on the same edge; last_winner updates to g.
REQ-027 Granted req falling without pix_last (abort): grant clears and state = IDLE next edge; last_winner updates; pixel accepted in that same cycle is still plotted.
REQ-028 A minimum of one IDLE cycle separates bursts; back-to-back grants to different requesters are therefore 2 cycles apart.
REQ-029 Burst counter (width ceil(log2(MAX_BURST+1))) clears on grant and increments each BURST cycle.
REQ-030 Counter reaching MAX_BURST-1 in BURST: forced release as in REQ-027 and timeout_err sets.
REQ-031 timeout_err stays set until clr_err; simultaneous set and clear: set wins.
REQ-032 x_out/y_out/colour_out hold their last value when plot = 0.
REQ-033 busy = (state == BURST); grant != 0 exactly when busy = 1.

Reset
REQ-034 reset_n low asynchronously forces state IDLE, grant 0, plot 0, busy 0, x_out/y_out/colour_out 0, timeout_err 0, burst counter 0, last_winner 2 (so requester 0 has first priority).
REQ-035 Reset asserted mid-burst drops grant and plot immediately, with no completion of the pending pixel; requesters must re-request after release.

Verification
REQ-036 req=3'b111 from reset -> grants issue in order 0,1,2,0, each burst ended by pix_last, with 1 IDLE cycle between grants.
REQ-037 Requester 1 granted, pix_valid=3'b011 with x_in[1]=10, y_in[1]=20, colour_in[1]=3'b100 -> next cycle plot=1, x_out=10, y_out=20, colour_out=4; requester-0 pixel dropped.
REQ-038 Granted requester drops req mid-burst -> grant=0 and busy=0 on the next edge; next arbitration starts from the following index.
REQ-039 MAX_BURST=8, granted requester never asserts pix_last -> release after 8 BURST cycles; timeout_err=1 until clr_err pulse, then 0.
REQ-040 reset_n pulsed low mid-burst asynchronously (between clock edges) -> all outputs 0 before the next edge; after release with req=3'b110, requester 1 is granted first.

Source files
------------

// File: rtl/plot_arbiter_if.sv
// Bundles the three requester pixel ports and the single VGA pixel output of plot_arbiter.
// master = requester/VGA side, slave = arbiter side.
// Requester i occupies bits [i*W +: W] of each packed coordinate and colour bus.
interface plot_arbiter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic [2:0]       req;
  logic [2:0]       pix_valid;
  logic [2:0]       pix_last;
  logic [3*X_W-1:0] x_in;
  logic [3*Y_W-1:0] y_in;
  logic [3*C_W-1:0] colour_in;
  logic             clr_err;
  logic [2:0]       grant;
  logic             busy;
  logic             plot;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [C_W-1:0]   colour_out;
  logic             timeout_err;

  modport master (
    output req, pix_valid, pix_last, x_in, y_in, colour_in, clr_err,
    input  grant, busy, plot, x_out, y_out, colour_out, timeout_err
  );

  modport slave (
    input  req, pix_valid, pix_last, x_in, y_in, colour_in, clr_err,
    output grant, busy, plot, x_out, y_out, colour_out, timeout_err
  );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter granting one of three pixel sources bursts onto a single VGA write port.
// Latency: grant 1 cycle after request in IDLE; accepted pixel appears on plot 1 cycle later.
// Backpressure: non-granted sources wait on req; a watchdog forces release after MAX_BURST cycles.
module plot_arbiter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int MAX_BURST = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  plot_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d, x_sel;
  logic [Y_W-1:0]   y_q, y_d, y_sel;
  logic [C_W-1:0]   c_q, c_d, c_sel;
  logic [1:0]       win_idx, g_idx, cand1, cand2, cand3;
  logic             win_vld;
  logic             accept, last_hit, req_hold;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin pick: scan from the source after the last winner; nearest requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand1   = next_idx(last_q);
    cand2   = next_idx(cand1);
    cand3   = next_idx(cand2);
    if (bus.req[cand3]) begin win_vld = 1'b1; win_idx = cand3; end
    if (bus.req[cand2]) begin win_vld = 1'b1; win_idx = cand2; end
    if (bus.req[cand1]) begin win_vld = 1'b1; win_idx = cand1; end
  end

  // Decode the granted source and mux its pixel fields; only the granted source is ever seen.
  always_comb begin
    g_idx = 2'd0;
    x_sel = '0;
    y_sel = '0;
    c_sel = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q[i]) begin
        g_idx = 2'(i);
        x_sel = bus.x_in[i*X_W +: X_W];
        y_sel = bus.y_in[i*Y_W +: Y_W];
        c_sel = bus.colour_in[i*C_W +: C_W];
      end
    end
  end

  assign accept   = |(bus.pix_valid & grant_q);
  assign last_hit = |(bus.pix_valid & bus.pix_last & grant_q);
  assign req_hold = |(bus.req & grant_q);

  // Next-state and output decode; any release path returns to IDLE, guaranteeing a gap cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    err_d   = err_q & ~bus.clr_err;
    case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        if (win_vld) begin
          state_d = BURST;
          grant_d = 3'b001 << win_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (accept) begin
          plot_d = 1'b1;
          x_d    = x_sel;
          y_d    = y_sel;
          c_d    = c_sel;
        end
        if (last_hit || !req_hold) begin
          state_d = IDLE;
          grant_d = 3'b000;
          last_d  = g_idx;
        end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // Watchdog: source overstayed its burst; evict it and flag the error (set beats clear).
          state_d = IDLE;
          grant_d = 3'b000;
          last_d  = g_idx;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q == BURST);
  assign bus.plot        = plot_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.colour_out  = c_q;
  assign bus.timeout_err = err_q;
endmodule
